// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multicycle control FSM for the rv32i-pico core. It steps each instruction
// through FETCH, DECODE, EXEC, MEM and WB. Along the way it drives the shared
// memory port, the IR/PC latches, the ALU operand and op-class selects, and
// the register-file write port. It also counts retired instructions and
// raises sticky flags for illegal opcodes and memory timeouts.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset; also forces all strobes low
//   i_opcode     opcode field of the current IR
//   i_zero       ALU zero flag (beq condition)
//   i_mem_ready  memory accepts/completes the current transfer this cycle
//   o_mem_req    memory request
//   o_mem_we     memory write (store)
//   o_addr_sel   memory address select: 0 = PC, 1 = ALU result register
//   o_ir_we      latch IR and old_pc
//   o_pc_we      PC write enable
//   o_pc_src     0 = PC+4, 1 = old_pc+imm
//   o_alu_src_b  00 = rs2, 01 = imm, 10 = const 4
//   o_alu_op     00 = add, 01 = sub, 10 = decode by func fields
//   o_reg_we     register-file write
//   o_wb_sel     0 = ALU result, 1 = memory data
//   o_illegal    sticky illegal-opcode flag
//   o_bus_err    sticky memory-timeout flag
//   o_retired    retired-instruction count (wraps)
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [6:0]           i_opcode,
  input  logic                 i_zero,
  input  logic                 i_mem_ready,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic                 o_addr_sel,
  output logic                 o_ir_we,
  output logic                 o_pc_we,
  output logic                 o_pc_src,
  output logic [1:0]           o_alu_src_b,
  output logic [1:0]           o_alu_op,
  output logic                 o_reg_we,
  output logic                 o_wb_sel,
  output logic                 o_illegal,
  output logic                 o_bus_err,
  output logic [CNT_WIDTH-1:0] o_retired
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  // The last wait-counter value that is still allowed to see mem_ready.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // The instruction class is captured in DECODE. Later states then do not
  // depend on the IR staying stable.
  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LD  = 3'd2,
    C_ST  = 3'd3,
    C_BEQ = 3'd4
  } cls_t;

  state_t               r_state;
  cls_t                 r_cls;
  logic [7:0]           r_wait;
  logic                 r_illegal;
  logic                 r_bus_err;
  logic [CNT_WIDTH-1:0] r_retired;

  assign o_illegal = r_illegal;
  assign o_bus_err = r_bus_err;
  assign o_retired = r_retired;

  // Strobe decode from state (plus mem_ready/zero), held low during reset.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_addr_sel  = 1'b0;
    o_ir_we     = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_src    = 1'b0;
    o_alu_src_b = 2'b00;
    o_alu_op    = 2'b00;
    o_reg_we    = 1'b0;
    o_wb_sel    = 1'b0;
    if (!i_rst_n) begin
      o_mem_req = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          o_mem_req = 1'b1;
          o_ir_we   = i_mem_ready;
          o_pc_we   = i_mem_ready;
        end
        S_EXEC: begin
          case (r_cls)
            C_R: begin
              o_alu_src_b = 2'b00;
              o_alu_op    = 2'b10;
            end
            C_I: begin
              o_alu_src_b = 2'b01;
              o_alu_op    = 2'b10;
            end
            C_LD, C_ST: begin
              o_alu_src_b = 2'b01;
              o_alu_op    = 2'b00;
            end
            C_BEQ: begin
              o_alu_src_b = 2'b00;
              o_alu_op    = 2'b01;
              o_pc_src    = 1'b1;
              o_pc_we     = i_zero;
            end
            default: o_alu_op = 2'b00;
          endcase
        end
        S_MEM: begin
          o_mem_req  = 1'b1;
          o_addr_sel = 1'b1;
          o_mem_we   = (r_cls == C_ST);
        end
        S_WB: begin
          o_reg_we = 1'b1;
          o_wb_sel = (r_cls == C_LD);
        end
        default: o_mem_req = 1'b0;
      endcase
    end
  end

  // State sequencing, memory wait counter, sticky flags and retire counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cls     <= C_R;
      r_wait    <= 8'd0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wait  <= 8'd0;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          // A ready in the last allowed cycle still wins over the timeout.
          if (i_mem_ready) begin
            r_state <= S_DECODE;
          end else if (r_wait == WAIT_LAST) begin
            r_bus_err <= 1'b1;
            r_state   <= S_TRAP;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
          case (i_opcode)
            OP_RTYPE: r_cls <= C_R;
            OP_ITYPE: r_cls <= C_I;
            OP_LOAD:  r_cls <= C_LD;
            OP_STORE: r_cls <= C_ST;
            OP_BEQ:   r_cls <= C_BEQ;
            default: begin
              r_illegal <= 1'b1;
              r_state   <= S_TRAP;
            end
          endcase
        end
        S_EXEC: begin
          r_wait <= 8'd0;
          case (r_cls)
            C_R, C_I:   r_state <= S_WB;
            C_LD, C_ST: r_state <= S_MEM;
            C_BEQ: begin
              r_retired <= r_retired + CNT_WIDTH'(1);
              r_state   <= S_FETCH;
            end
            default: r_state <= S_TRAP;
          endcase
        end
        S_MEM: begin
          if (i_mem_ready) begin
            if (r_cls == C_ST) begin
              r_retired <= r_retired + CNT_WIDTH'(1);
              r_wait    <= 8'd0;
              r_state   <= S_FETCH;
            end else begin
              r_state <= S_WB;
            end
          end else if (r_wait == WAIT_LAST) begin
            r_bus_err <= 1'b1;
            r_state   <= S_TRAP;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB: begin
          r_retired <= r_retired + CNT_WIDTH'(1);
          r_wait    <= 8'd0;
          r_state   <= S_FETCH;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
